// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between an I-side refill requester and a
// D-side refill/writeback requester, one cache-line burst at a time.
// Optional feature: define ARB_RR_EN for round-robin arbitration; without it
// the D-side has fixed priority on simultaneous requests.
module mem_arbiter #(
  parameter int LINE_WORDS = 8,
  parameter int ADDR_LEN   = 32
) (
  input  logic                clk,
  input  logic                rst,
  // I-side
  input  logic                i_req,
  input  logic [ADDR_LEN-1:0] i_addr,
  output logic                i_gnt,
  output logic [31:0]         i_rdata,
  output logic                i_rvalid,
  output logic                i_done,
  // D-side
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_LEN-1:0] d_addr,
  input  logic [31:0]         d_wdata,
  output logic                d_gnt,
  output logic [31:0]         d_rdata,
  output logic                d_rvalid,
  output logic                d_wnext,
  output logic                d_done,
  // memory
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_LEN-1:0] mem_addr,
  output logic [31:0]         mem_wdata,
  input  logic [31:0]         mem_rdata,
  input  logic                mem_ready,
  output logic                busy
);

  localparam int BW   = $clog2(LINE_WORDS);
  localparam int OFFS = BW + 2;
  localparam logic [ADDR_LEN-1:0] LINE_MASK = {ADDR_LEN{1'b1}} << OFFS;
  localparam logic [BW-1:0]       LAST_BEAT = BW'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, GRANT, BURST, DONE} state_t;

  state_t              state;
  state_t              state_nxt;
  logic                win_d;
  logic                lat_we;
  logic [ADDR_LEN-1:0] base_q;
  logic [BW-1:0]       beat;
  logic                any_req;
  logic                pick_d;

  assign any_req = i_req | d_req;
  assign busy    = (state != IDLE);

`ifdef ARB_RR_EN
  logic last_d;

  // Remember which side was granted last so the other side wins a tie next time.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_d <= 1'b0;
    end else if (state == GRANT) begin
      last_d <= win_d;
    end
  end

  assign pick_d = d_req & (~i_req | ~last_d);
`else
  assign pick_d = d_req;
`endif

  // State register; reset drops straight back to IDLE, aborting any burst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Latch the winner, its direction and its line base; step the beat counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_d  <= 1'b0;
      lat_we <= 1'b0;
      base_q <= '0;
      beat   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            win_d  <= pick_d;
            lat_we <= pick_d & d_we;
            base_q <= (pick_d ? d_addr : i_addr) & LINE_MASK;
          end
        end
        GRANT: beat <= '0;
        BURST: begin
          if (mem_ready && (beat != LAST_BEAT)) begin
            beat <= beat + BW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state and all outputs; only the winner's strobes are ever driven.
  always_comb begin
    state_nxt = state;
    i_gnt     = 1'b0;
    i_rdata   = '0;
    i_rvalid  = 1'b0;
    i_done    = 1'b0;
    d_gnt     = 1'b0;
    d_rdata   = '0;
    d_rvalid  = 1'b0;
    d_wnext   = 1'b0;
    d_done    = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        i_gnt     = ~win_d;
        d_gnt     = win_d;
        state_nxt = BURST;
      end
      BURST: begin
        mem_req  = 1'b1;
        mem_we   = lat_we;
        mem_addr = base_q | ADDR_LEN'({beat, 2'b00});
        if (lat_we) begin
          mem_wdata = d_wdata;
        end
        if (mem_ready) begin
          if (lat_we) begin
            d_wnext = 1'b1;
          end else if (win_d) begin
            d_rvalid = 1'b1;
            d_rdata  = mem_rdata;
          end else begin
            i_rvalid = 1'b1;
            i_rdata  = mem_rdata;
          end
          if (beat == LAST_BEAT) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        i_done    = ~win_d;
        d_done    = win_d;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter (LINE_WORDS=8).
// Expectations for simultaneous requests follow ARB_RR_EN when it is defined.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic [31:0] i_rdata;
  logic        i_rvalid;
  logic        i_done;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic [31:0] d_rdata;
  logic        d_rvalid;
  logic        d_wnext;
  logic        d_done;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        busy;

  int errors = 0;
  int checks = 0;

  mem_arbiter #(.LINE_WORDS(8), .ADDR_LEN(32)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rdata(i_rdata),
    .i_rvalid(i_rvalid), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rdata(d_rdata), .d_rvalid(d_rvalid),
    .d_wnext(d_wnext), .d_done(d_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy)
  );

  // Free-running core clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Backstop so the run always ends even if the sequence stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Walks the eight read beats of a granted burst with mem_ready held high,
  // then the DONE cycle; requests are dropped at beat drop_at (8 = at done).
  task automatic run_burst(input string tag, input logic [31:0] base, input logic is_d,
                           input int drop_at);
    logic [31:0] rd;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      rd        = 32'hC0DE_0000 + 32'(k);
      mem_ready = 1'b1;
      mem_rdata = rd;
      if (k == drop_at) begin
        i_req = 1'b0;
        d_req = 1'b0;
      end
      #1;
      check_output({tag, "_mem_req"}, 32'(mem_req), 32'd1);
      check_output({tag, "_mem_we"}, 32'(mem_we), 32'd0);
      check_output({tag, "_mem_addr"}, mem_addr, base + 32'(4 * k));
      check_output({tag, "_gnt"}, 32'({i_gnt, d_gnt}), 32'd0);
      if (is_d) begin
        check_output({tag, "_d_rvalid"}, 32'(d_rvalid), 32'd1);
        check_output({tag, "_d_rdata"}, d_rdata, rd);
        check_output({tag, "_i_rvalid"}, 32'(i_rvalid), 32'd0);
      end else begin
        check_output({tag, "_i_rvalid"}, 32'(i_rvalid), 32'd1);
        check_output({tag, "_i_rdata"}, i_rdata, rd);
        check_output({tag, "_d_rvalid"}, 32'(d_rvalid), 32'd0);
      end
    end
    @(negedge clk);
    mem_ready = 1'b0;
    if (drop_at == 8) begin
      i_req = 1'b0;
      d_req = 1'b0;
    end
    #1;
    check_output({tag, "_i_done"}, 32'(i_done), 32'(!is_d));
    check_output({tag, "_d_done"}, 32'(d_done), 32'(is_d));
    check_output({tag, "_done_mem_req"}, 32'(mem_req), 32'd0);
    check_output({tag, "_done_busy"}, 32'(busy), 32'd1);
  endtask

  // Linear directed sequence covering reset, reads, writeback, arbitration and abort.
  initial begin
    int beats;
    int cyc;
    rst = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;

    // Reset state, even with a request pending
    repeat (2) @(negedge clk);
    i_req = 1'b1;
    mem_ready = 1'b1;
    #1;
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_mem_req", 32'(mem_req), 32'd0);
    check_output("rst_gnt", 32'({i_gnt, d_gnt}), 32'd0);
    check_output("rst_strobes", 32'({i_rvalid, d_rvalid, d_wnext, i_done, d_done}), 32'd0);
    check_output("rst_mem_addr", mem_addr, 32'd0);
    @(negedge clk);
    #1;
    check_output("rst_hold_busy", 32'(busy), 32'd0);
    i_req = 1'b0;
    mem_ready = 1'b0;
    rst = 1'b1;

    // Single I refill from 0x1234
    $display("[TB] I refill 0x1234");
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h1234;
    #1;
    check_output("a_c0_busy", 32'(busy), 32'd0);
    @(negedge clk);
    #1;
    check_output("a_c1_i_gnt", 32'(i_gnt), 32'd1);
    check_output("a_c1_d_gnt", 32'(d_gnt), 32'd0);
    check_output("a_c1_mem_req", 32'(mem_req), 32'd0);
    run_burst("a", 32'h1220, 1'b0, 8);
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    check_output("a_idle_busy", 32'(busy), 32'd0);
    check_output("a_idle_rvalid", 32'(i_rvalid), 32'd0);
    mem_ready = 1'b0;

    // I refill with the request dropped at beat 2
    $display("[TB] I refill with early req drop");
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h4008;
    #1;
    @(negedge clk);
    #1;
    check_output("e_i_gnt", 32'(i_gnt), 32'd1);
    run_burst("e", 32'h4000, 1'b0, 2);
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    check_output("e_idle_busy", 32'(busy), 32'd0);
    check_output("e_idle_rvalid", 32'(i_rvalid), 32'd0);
    check_output("e_idle_mem_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    #1;
    check_output("e_no_regrant", 32'({busy, i_gnt}), 32'd0);
    mem_ready = 1'b0;

    // D writeback from 0x80 with mem_ready every other cycle
    $display("[TB] D writeback 0x80");
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80;
    #1;
    check_output("b_c0_busy", 32'(busy), 32'd0);
    @(negedge clk);
    #1;
    check_output("b_d_gnt", 32'(d_gnt), 32'd1);
    check_output("b_i_gnt", 32'(i_gnt), 32'd0);
    beats = 0;
    cyc = 0;
    while (beats < 8 && cyc < 40) begin
      @(negedge clk);
      mem_ready = cyc[0];
      d_wdata = 32'hDA7A_0000 + 32'(beats);
      #1;
      check_output("b_mem_req", 32'(mem_req), 32'd1);
      check_output("b_mem_we", 32'(mem_we), 32'd1);
      check_output("b_mem_addr", mem_addr, 32'h80 + 32'(4 * beats));
      check_output("b_mem_wdata", mem_wdata, 32'hDA7A_0000 + 32'(beats));
      check_output("b_d_wnext", 32'(d_wnext), 32'(mem_ready));
      check_output("b_d_rvalid", 32'(d_rvalid), 32'd0);
      if (mem_ready) beats++;
      cyc++;
    end
    check_output("b_beat_count", 32'(beats), 32'd8);
    @(negedge clk);
    mem_ready = 1'b0; d_req = 1'b0; d_we = 1'b0;
    #1;
    check_output("b_d_done", 32'(d_done), 32'd1);
    check_output("b_i_done", 32'(i_done), 32'd0);
    check_output("b_done_mem_req", 32'(mem_req), 32'd0);
    check_output("b_done_wnext", 32'(d_wnext), 32'd0);
    @(negedge clk);
    #1;
    check_output("b_done_once", 32'(d_done), 32'd0);
    check_output("b_idle_busy", 32'(busy), 32'd0);

    // Simultaneous requests from a fresh reset, both held across done
    $display("[TB] simultaneous requests");
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    i_addr = 32'h2000; d_addr = 32'h3000;
    #1;
    @(negedge clk);
    #1;
    check_output("c_first_d_gnt", 32'(d_gnt), 32'd1);
    check_output("c_first_i_gnt", 32'(i_gnt), 32'd0);
    run_burst("c1", 32'h3000, 1'b1, -1);
    @(negedge clk);
    #1;
    check_output("c_idle_busy", 32'(busy), 32'd0);
    check_output("c_idle_gnt", 32'({i_gnt, d_gnt}), 32'd0);
    @(negedge clk);
    #1;
`ifdef ARB_RR_EN
    check_output("c_second_i_gnt", 32'(i_gnt), 32'd1);
    check_output("c_second_d_gnt", 32'(d_gnt), 32'd0);
    run_burst("c2", 32'h2000, 1'b0, 8);
`else
    check_output("c_second_d_gnt", 32'(d_gnt), 32'd1);
    check_output("c_second_i_gnt", 32'(i_gnt), 32'd0);
    run_burst("c2", 32'h3000, 1'b1, 8);
`endif

    // Reset asserted at beat 3 of an I read, then regrant from beat 0
    $display("[TB] reset mid-burst");
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h5000;
    #1;
    @(negedge clk);
    #1;
    check_output("d_i_gnt", 32'(i_gnt), 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      mem_ready = 1'b1;
      #1;
      check_output("d_pre_addr", mem_addr, 32'h5000 + 32'(4 * k));
    end
    #1;
    rst = 1'b0;
    #1;
    check_output("d_abort_mem_req", 32'(mem_req), 32'd0);
    check_output("d_abort_busy", 32'(busy), 32'd0);
    check_output("d_abort_done", 32'(i_done), 32'd0);
    check_output("d_abort_rvalid", 32'(i_rvalid), 32'd0);
    @(negedge clk);
    #1;
    check_output("d_in_rst_busy", 32'(busy), 32'd0);
    check_output("d_in_rst_done", 32'(i_done), 32'd0);
    rst = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    #1;
    check_output("d_regrant", 32'(i_gnt), 32'd1);
    run_burst("d", 32'h5000, 1'b0, 8);
    @(negedge clk);
    #1;
    check_output("d_final_busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
